bilateral_window_fetch: RTL and testbench
=========================================

// Module: bilateral_window_fetch
// PURPOSE
//  Address-driven image fetch engine for the bilateral filter datapath.
//  - Reads an IMG_W x IMG_H 8-bit image from the host memory port (in_addr -> in_data, fixed READ_LAT) in raster order.
//  - Buffers 2*RADIUS lines and emits one K x K window (K = 2*RADIUS+1) per interior centre pixel on a valid/ready stream.
//  - Successor to the single-size fetch: window size, image size and read latency are parametrised; downstream backpressure is supported.
// PARAMETERS
//  IMG_W     256  image width in pixels
//  IMG_H     256  image height in pixels
//  RADIUS    2    window radius; K = 2*RADIUS+1
//  DW        8    pixel width in bits
//  READ_LAT  1    cycles from in_addr issue to in_data valid at the posedge (>=1)
//  AW        $clog2(IMG_W*IMG_H)  address width (16 at defaults)
// PORTS
//  clk        in   1        clock
//  rst        in   1        asynchronous reset, active-high
//  in_valid   in   1        host run enable; level; low pauses address issue
//  in_addr    out  AW       read address to host memory
//  in_data    in   DW       read data, returned READ_LAT cycles after in_addr
//  win_valid  out  1        window output valid
//  win_ready  in   1        downstream accepts the window when win_valid & win_ready
//  win_data   out  K*K*DW   window; element (i,j) at [(i*K+j)*DW +: DW] = pixel(y-R+i, x-R+j)
//  win_addr   out  AW       centre address y*IMG_W+x
//  finish     out  1        whole image processed
// BEHAVIOUR
//  - Reset values: in_addr=0, win_valid=0, win_data=0, win_addr=0, finish=0, FSM=IDLE. Line buffers and window registers are cleared, all counters are zeroed, return FIFO is empty.
//  - FSM states:
//    - IDLE: go to RUN on in_valid=1.
//    - RUN: go to DRAIN after address IMG_W*IMG_H-1 is issued.
//    - DRAIN: go to DONE when the last window is accepted.
//    - DONE: finish=1; go to IDLE when in_valid=0.
//  - Read issue: at most one read per cycle, only in RUN, and only when in_valid=1 and outstanding reads + return-FIFO occupancy < READ_LAT+1.
//    - in_addr increments by 1 per issued read.
//    - in_addr holds its value when no read is issued.
//  - Return path:
//    - A delay-line tag marks which cycles carry valid in_data.
//    - Valid data is pushed into a return FIFO of depth READ_LAT+1; the FIFO can never overflow by construction.
//  - Pop and shift:
//    - Pop one pixel from the FIFO when the FIFO is non-empty and the output register is empty or being accepted this cycle.
//    - On a pop, the pixel shifts into the K x K window registers and the line buffers (2*RADIUS lines of IMG_W).
//    - Row/column counters (r,c) of the popped pixel wrap at IMG_W and advance r.
//  - Emission:
//    - Occurs when the pixel popped this cycle has r>=2R and c>=2R; the centre is (r-R, c-R).
//    - win_valid, win_data and win_addr are registered 1 cycle after the pop.
//    - The emission order is raster over the interior, (IMG_W-2R)*(IMG_H-2R) windows in total.
//    - Border centres are never emitted.
//  - Stall: while win_valid=1 and win_ready=0, win_data and win_addr hold stable, and no pop occurs.
//  - Full throughput: with win_ready=1 and in_valid=1, one read and one pop per cycle. Total cycles from start to finish <= IMG_W*IMG_H + READ_LAT + 4.
//  - Pause: in_valid=0 in RUN stops issue only; in-flight data still lands in the FIFO, and emission continues.
//  - Simultaneous accept and new emission in the same cycle: the output register reloads with no bubble.
//  - rst mid-operation: immediate return to the reset state; in-flight in_data is discarded.
// TESTING
//  - Common setup: host memory model with mem[a] = a[7:0].
//  - T1 reset: assert rst mid-RUN -> next cycle win_valid=0, finish=0, in_addr=0.
//  - T2 full run, IMG_W=8, IMG_H=6, RADIUS=1, READ_LAT=1, win_ready=1 -> expect:
//    - exactly 24 windows;
//    - first window win_addr=9, centre=9, top-left=0, bottom-right=18;
//    - last window win_addr=38;
//    - finish rises <=4 cycles after in_addr=47 is issued.
//  - T3 backpressure: T2 with win_ready random at 50% -> identical 24-window sequence, no drop or duplicate, win_data stable across every stalled cycle.
//  - T4 latency: READ_LAT=3 with T3 stimulus -> identical sequence; outstanding reads never exceed 4.
//  - T5 pause: in_valid=0 for 10 cycles after 20 reads -> in_addr frozen during the pause, identical output sequence.
//  - T6 default size, RADIUS=2, IMG_W=IMG_H=256 -> 63504 windows; window (i,j) = mem[addr+(i-2)*256+(j-2)]; finish within 65541 cycles.

Source files
------------

// File: rtl/bilateral_window_fetch.sv
// rtl/bilateral_window_fetch.sv - raster image fetch engine emitting K x K windows for the bilateral filter
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   in_valid         host run enable (level); low pauses read issue
//   in_addr          read address to host memory
//   in_data          read data, valid READ_LAT cycles after in_addr
//   win_valid/ready  window stream handshake
//   win_data         K*K pixels, element (i,j) at [(i*K+j)*DW +: DW]
//   win_addr         centre pixel address y*IMG_W+x
//   finish           whole image processed
module bilateral_window_fetch #(
    parameter int IMG_W    = 256,
    parameter int IMG_H    = 256,
    parameter int RADIUS   = 2,
    parameter int DW       = 8,
    parameter int READ_LAT = 1,
    parameter int AW       = $clog2(IMG_W*IMG_H)
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic                                            in_valid,
    output logic [AW-1:0]                                   in_addr,
    input  logic [DW-1:0]                                   in_data,
    output logic                                            win_valid,
    input  logic                                            win_ready,
    output logic [(2*RADIUS+1)*(2*RADIUS+1)*DW-1:0]         win_data,
    output logic [AW-1:0]                                   win_addr,
    output logic                                            finish
);

    localparam int K        = 2*RADIUS + 1;
    localparam int NLB      = 2*RADIUS;
    localparam int NPIX     = IMG_W*IMG_H;
    localparam int DEPTH    = READ_LAT + 1;
    localparam int PW       = $clog2(DEPTH);
    localparam int CNTW     = $clog2(DEPTH + 1);
    localparam int XW       = $clog2(IMG_W);
    localparam int YW       = $clog2(IMG_H + 1);
    localparam int CTR_OFS  = RADIUS*IMG_W + RADIUS;
    localparam int LAST_CTR = (IMG_H-1-RADIUS)*IMG_W + (IMG_W-1-RADIUS);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                 state_q;
    logic                   finish_q;
    logic [AW-1:0]          addr_q, addr_d;
    logic [READ_LAT-1:0]    tag_q, tag_d;
    logic [READ_LAT:0]      tag_ext;
    logic [DW-1:0]          fifo_q [DEPTH];
    logic [PW-1:0]          wr_ptr_q, rd_ptr_q;
    logic [CNTW-1:0]        cnt_q, cnt_d;
    logic [XW-1:0]          x_q, x_d;
    logic [YW-1:0]          y_q, y_d;
    logic [AW-1:0]          pix_addr_q, pix_addr_d;
    logic [DW-1:0]          lb_q [NLB][IMG_W];
    logic [DW-1:0]          win_q [K][K];
    logic [DW-1:0]          nxt [K][K];
    logic [DW-1:0]          col [K];
    logic [DW-1:0]          pix;
    logic                   win_valid_q, win_valid_d;
    logic [K*K*DW-1:0]      win_data_q;
    logic [AW-1:0]          win_addr_q;
    logic [7:0]             inflight, occ;
    logic                   issue, push, pop, emit, accept, frame_end;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        inflight = '0;
        for (int l = 0; l < READ_LAT; l++) begin
            inflight = inflight + 8'(tag_q[l]);
        end
        pop    = (cnt_q != '0) && (!win_valid_q || win_ready);
        // Credit includes the slot freed by this cycle's pop so full rate is sustained.
        occ    = inflight + 8'(cnt_q) - 8'(pop);
        issue  = (state_q == S_RUN) && in_valid && (occ < 8'(DEPTH));
        push   = tag_q[READ_LAT-1];
        tag_ext = {tag_q, issue};
        tag_d  = tag_ext[READ_LAT-1:0];
        pix    = fifo_q[rd_ptr_q];

        // lb_q[l] holds row (y-1-l); the new pixel is the bottom of the column.
        col[K-1] = pix;
        for (int l = 0; l < NLB; l++) begin
            col[K-2-l] = lb_q[l][x_q];
        end
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K-1; j++) begin
                nxt[i][j] = win_q[i][j+1];
            end
            nxt[i][K-1] = col[i];
        end

        emit      = pop && (y_q >= YW'(NLB)) && (x_q >= XW'(NLB));
        accept    = win_valid_q && win_ready;
        frame_end = (state_q == S_DONE) && !in_valid;

        cnt_d = cnt_q + CNTW'(push) - CNTW'(pop);

        addr_d = addr_q;
        if (frame_end) begin
            addr_d = '0;
        end else if (issue) begin
            addr_d = addr_q + AW'(1);
        end

        x_d        = x_q;
        y_d        = y_q;
        pix_addr_d = pix_addr_q;
        if (frame_end) begin
            x_d        = '0;
            y_d        = '0;
            pix_addr_d = '0;
        end else if (pop) begin
            pix_addr_d = pix_addr_q + AW'(1);
            if (x_q == XW'(IMG_W-1)) begin
                x_d = '0;
                y_d = y_q + YW'(1);
            end else begin
                x_d = x_q + XW'(1);
            end
        end

        win_valid_d = win_valid_q;
        if (emit) begin
            win_valid_d = 1'b1;
        end else if (accept) begin
            win_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            finish_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE:  if (in_valid) state_q <= S_RUN;
                S_RUN:   if (issue && addr_q == AW'(NPIX-1)) state_q <= S_DRAIN;
                S_DRAIN: if (accept && win_addr_q == AW'(LAST_CTR)) begin
                    state_q  <= S_DONE;
                    finish_q <= 1'b1;
                end
                S_DONE:  if (!in_valid) begin
                    state_q  <= S_IDLE;
                    finish_q <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q      <= '0;
            tag_q       <= '0;
            cnt_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            x_q         <= '0;
            y_q         <= '0;
            pix_addr_q  <= '0;
            win_valid_q <= 1'b0;
            win_data_q  <= '0;
            win_addr_q  <= '0;
            for (int d = 0; d < DEPTH; d++) begin
                fifo_q[d] <= '0;
            end
            for (int l = 0; l < NLB; l++) begin
                for (int w = 0; w < IMG_W; w++) begin
                    lb_q[l][w] <= '0;
                end
            end
            for (int i = 0; i < K; i++) begin
                for (int j = 0; j < K; j++) begin
                    win_q[i][j] <= '0;
                end
            end
        end else begin
            addr_q      <= addr_d;
            tag_q       <= tag_d;
            cnt_q       <= cnt_d;
            x_q         <= x_d;
            y_q         <= y_d;
            pix_addr_q  <= pix_addr_d;
            win_valid_q <= win_valid_d;
            if (push) begin
                fifo_q[wr_ptr_q] <= in_data;
                wr_ptr_q         <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q      <= ptr_inc(rd_ptr_q);
                lb_q[0][x_q]  <= pix;
                for (int l = 1; l < NLB; l++) begin
                    lb_q[l][x_q] <= lb_q[l-1][x_q];
                end
                for (int i = 0; i < K; i++) begin
                    for (int j = 0; j < K; j++) begin
                        win_q[i][j] <= nxt[i][j];
                    end
                end
            end
            if (emit) begin
                win_addr_q <= pix_addr_q - AW'(CTR_OFS);
                for (int i = 0; i < K; i++) begin
                    for (int j = 0; j < K; j++) begin
                        win_data_q[(i*K+j)*DW +: DW] <= nxt[i][j];
                    end
                end
            end
        end
    end

    assign in_addr   = addr_q;
    assign win_valid = win_valid_q;
    assign win_data  = win_data_q;
    assign win_addr  = win_addr_q;
    assign finish    = finish_q;

endmodule

// File: tb/tb_bilateral_window_fetch.sv
// tb/tb_bilateral_window_fetch.sv - directed bench for bilateral_window_fetch over three configurations
module tb_bilateral_window_fetch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int ndone = 0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic mark_done();
        ndone++;
    endtask

    for (genvar g = 0; g < 3; g++) begin : cfg
        localparam int W    = (g == 2) ? 256 : 8;
        localparam int H    = (g == 2) ? 256 : 6;
        localparam int R    = (g == 2) ? 2 : 1;
        localparam int L    = (g == 1) ? 3 : 1;
        localparam int K    = 2*R + 1;
        localparam int N    = W*H;
        localparam int AW   = $clog2(N);
        localparam int NWIN = (W-2*R)*(H-2*R);

        logic              rst, in_valid, win_ready, win_valid, finish;
        logic [AW-1:0]     in_addr, win_addr;
        logic [7:0]        in_data;
        logic [K*K*8-1:0]  win_data;
        logic [AW-1:0]     apipe [L];

        // Host memory: mem[a] = a[7:0], returned L cycles after the address.
        always @(posedge clk) begin
            apipe[0] <= in_addr;
            for (int s = 1; s < L; s++) apipe[s] <= apipe[s-1];
        end
        assign in_data = 8'(apipe[L-1]);

        bilateral_window_fetch #(
            .IMG_W(W), .IMG_H(H), .RADIUS(R), .DW(8), .READ_LAT(L), .AW(AW)
        ) dut (
            .clk(clk), .rst(rst), .in_valid(in_valid), .in_addr(in_addr), .in_data(in_data),
            .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data),
            .win_addr(win_addr), .finish(finish)
        );

        function automatic int exp_ctr(input int k);
            return (R + k/(W-2*R))*W + R + k%(W-2*R);
        endfunction

        function automatic logic [255:0] exp_win(input int k);
            logic [255:0] v;
            int y, x, a;
            v = '0;
            y = R + k/(W-2*R);
            x = R + k%(W-2*R);
            for (int i = 0; i < K; i++) begin
                for (int j = 0; j < K; j++) begin
                    a = (y-R+i)*W + (x-R+j);
                    v[(i*K+j)*8 +: 8] = 8'(a);
                end
            end
            return v;
        endfunction

        task automatic init_reset();
            rst = 1'b1; in_valid = 1'b0; win_ready = 1'b0;
            repeat (3) @(negedge clk);
            rst = 1'b0;
            @(negedge clk);
            chk("rst_win_valid", win_valid, 0);
            chk("rst_finish", finish, 0);
            chk("rst_in_addr", in_addr, 0);
            chk("rst_win_addr", win_addr, 0);
            chk("rst_win_data", win_data, 0);
        endtask

        task automatic run_frame(input int rdy_pct, input int pause_at, input bit full_tp, input bit spec_consts);
            int k, cyc, t_last, stall_iss, pause_left;
            bit prev_stall, paused, iss;
            logic [AW-1:0] prev_addr;
            k = 0; cyc = 0; t_last = -1; stall_iss = 0; pause_left = 0;
            prev_stall = 1'b0; paused = 1'b0;
            prev_addr = in_addr;
            in_valid = 1'b1;
            while (!finish && cyc < 3*N + 200) begin
                @(negedge clk);
                cyc++;
                iss = (in_addr != prev_addr);
                prev_addr = in_addr;
                if (prev_stall) begin
                    stall_iss += int'(iss);
                    chk("stall_reads", stall_iss <= L+1, 1);
                end else begin
                    stall_iss = 0;
                end
                if (t_last < 0 && in_addr == AW'(N-1)) t_last = cyc;
                if (pause_left > 0) begin
                    chk("pause_addr", in_addr, pause_at);
                    pause_left--;
                    if (pause_left == 0) in_valid = 1'b1;
                end else if (!paused && pause_at >= 0 && in_addr == AW'(pause_at)) begin
                    paused = 1'b1;
                    pause_left = 10;
                    in_valid = 1'b0;
                end
                win_ready = ($urandom_range(0, 99) < rdy_pct);
                if (win_valid) begin
                    chk("win_addr", win_addr, exp_ctr(k));
                    chk("win_data", win_data, exp_win(k));
                    if (spec_consts && k == 0) begin
                        chk("first_addr", win_addr, 9);
                        chk("first_centre", win_data[4*8 +: 8], 9);
                        chk("first_topleft", win_data[7:0], 0);
                        chk("first_botright", win_data[8*8 +: 8], 18);
                    end
                    if (spec_consts && k == NWIN-1) chk("last_addr", win_addr, 38);
                    if (win_ready) k++;
                end
                prev_stall = win_valid && !win_ready;
            end
            chk("finish", finish, 1);
            chk("win_count", k, NWIN);
            if (full_tp) begin
                chk("fin_latency", (t_last >= 0) && (cyc - t_last <= 4), 1);
                chk("total_cycles", cyc <= N + L + 4, 1);
            end
            in_valid = 1'b0;
            @(negedge clk);
            chk("finish_clr", finish, 0);
            chk("idle_addr", in_addr, 0);
        endtask

        if (g == 0) begin : plan
            initial begin
                init_reset();
                in_valid = 1'b1; win_ready = 1'b1;
                repeat (25) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                chk("t1_win_valid", win_valid, 0);
                chk("t1_finish", finish, 0);
                chk("t1_in_addr", in_addr, 0);
                rst = 1'b0; in_valid = 1'b0;
                @(negedge clk);
                run_frame(100, -1, 1'b1, 1'b1);
                run_frame(50, -1, 1'b0, 1'b1);
                run_frame(100, 20, 1'b0, 1'b1);
                mark_done();
            end
        end else if (g == 1) begin : plan
            initial begin
                init_reset();
                run_frame(50, -1, 1'b0, 1'b0);
                mark_done();
            end
        end else begin : plan
            initial begin
                init_reset();
                run_frame(100, -1, 1'b1, 1'b0);
                mark_done();
            end
        end
    end

    initial begin
        for (int c = 0; c < 95000 && ndone < 3; c++) @(posedge clk);
        if (ndone < 3) chk("timeout", ndone, 3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
